// File: rtl/instruction_fetch.sv
// Fetch front end: owns the PC, issues in-order word reads, buffers them for the decoder; FETCH_PERF_EN adds perf counters.
// Latency: request accept to out_valid is memory latency + 1 cycle; no zero-cycle bypass.
// Backpressure: requests are credit-limited by FIFO count + outstanding, so out_ready stalls throttle fetch without overflow.

module fetch_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop_rdy)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_vld) - CW'(pop_rdy);
        end
    end

    always_ff @(posedge clock) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module instruction_fetch #(
    parameter int                PC_WIDTH    = 16,
    parameter int                INSTR_WIDTH = 32,
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic                   mem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_flushed,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instruction,
    output logic [PC_WIDTH-1:0]    out_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [PC_WIDTH-1:0]             fetch_pc;
    logic [PC_WIDTH-1:0]             rsp_pc;
    logic [CW-1:0]                   outstanding;
    logic [CW-1:0]                   outstanding_nxt;
    logic [CW-1:0]                   drop;
    logic [CW-1:0]                   count;
    logic [CW:0]                     credit_used;
    logic                            req_fire;
    logic                            rsp_push;
    logic                            rsp_drop;
    logic                            pop;
    logic [INSTR_WIDTH+PC_WIDTH-1:0] head_dat;

    assign credit_used   = {1'b0, count} + {1'b0, outstanding};
    assign mem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign mem_addr      = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_drop = mem_rsp_valid && (drop != '0);
    assign rsp_push = mem_rsp_valid && (drop == '0) && !redirect_valid;

    assign out_valid       = !reset && (count != '0);
    assign pop             = out_valid && out_ready;
    assign out_instruction = head_dat[INSTR_WIDTH+PC_WIDTH-1:PC_WIDTH];
    assign out_pc          = head_dat[PC_WIDTH-1:0];

    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(mem_rsp_valid);

    fetch_fifo #(
        .WIDTH (INSTR_WIDTH + PC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (redirect_valid),
        .push_vld (rsp_push),
        .push_dat ({mem_rsp_data, rsp_pc}),
        .pop_rdy  (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    // Everything still in flight after a redirect belongs to the old path and is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                drop     <= outstanding_nxt;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_WIDTH'(1);
                if (rsp_push) rsp_pc   <= rsp_pc + PC_WIDTH'(1);
                if (rsp_drop) drop     <= drop - CW'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [CW-1:0] flushed_inc;

    // A response landing on the redirect cycle is discarded along with the FIFO contents.
    assign flushed_inc = (redirect_valid ? (count - CW'(pop)) : '0)
                       + CW'(mem_rsp_valid && ((drop != '0) || redirect_valid));

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop);
            perf_flushed <= perf_flushed + 32'(flushed_inc);
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: behavioural in-order memory with programmable latency,
// output monitor and hand-computed expectations for streaming, stall, redirect and PC wrap.
module tb_instruction_fetch;
    logic        clock;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [15:0] out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_acc = 0;
    int lat   = 1;

    logic [15:0] got_q[$];
    logic [15:0] pend_addr[$];
    int          pend_due[$];

    instruction_fetch dut (
        .clock           (clock),
        .reset           (reset),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_addr        (mem_addr),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
`ifdef FETCH_PERF_EN
        .perf_fetched    (perf_fetched),
        .perf_flushed    (perf_flushed),
`endif
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] mem_data(input logic [15:0] a);
        return {a ^ 16'hBEEF, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model and output monitor: sample mid-cycle, act on the edge, drive responses after it.
    initial begin
        logic        rq, rs, oh, rst;
        logic [15:0] ra, op;
        logic [31:0] oi;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clock);
            #3;
            rst = reset;
            rq  = !reset && mem_req_valid && mem_req_ready;
            ra  = mem_addr;
            rs  = mem_rsp_valid;
            oh  = !reset && out_valid && out_ready;
            op  = out_pc;
            oi  = out_instruction;
            @(posedge clock);
            cyc++;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (rs && pend_addr.size() > 0) begin
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                if (rq) begin
                    pend_addr.push_back(ra);
                    pend_due.push_back(cyc + lat - 1);
                    n_acc++;
                end
            end
            if (oh) begin
                got_q.push_back(op);
                check("instr", oi, mem_data(op));
            end
            #1;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_data(pend_addr[0]);
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
            end
        end
    end

    // Leaves the bench at the start of the first cycle with reset low.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_req_vld", mem_req_valid, 0);
        check("rst_out_vld", out_valid, 0);
        reset = 1'b0;
        got_q.delete();
        n_acc = 0;
    endtask

    initial begin
        reset          = 1'b1;
        mem_req_ready  = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check("init_req_vld", mem_req_valid, 0);
        check("init_out_vld", out_valid, 0);

        // Streaming, latency 1.
        lat = 1;
        do_reset();
        #1;
        check("t1_req_vld", mem_req_valid, 1);
        check("t1_addr", mem_addr, 16'h0000);
        @(negedge clock);
        check("t1_c1_out_vld", out_valid, 0);
        @(negedge clock);
        check("t1_c2_out_vld", out_valid, 1);
        check("t1_c2_out_pc", out_pc, 16'h0000);
        repeat (8) @(negedge clock);
        check("t1_count", got_q.size() >= 8, 1);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check("t1_seq", got_q[i], i);

        // Decoder stall: exactly four requests, then drain in order.
        out_ready = 1'b0;
        do_reset();
        repeat (20) @(negedge clock);
        check("t2_accepts", n_acc, 4);
        check("t2_req_vld", mem_req_valid, 0);
        check("t2_out_vld", out_valid, 1);
        check("t2_head_pc", out_pc, 16'h0000);
        check("t2_none_out", got_q.size(), 0);
        out_ready = 1'b1;
        repeat (10) @(negedge clock);
        check("t2_count", got_q.size() >= 6, 1);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            check("t2_seq", got_q[i], i);

        // Latency 3, redirect with two requests in flight.
        lat = 3;
        out_ready = 1'b1;
        do_reset();
        repeat (2) @(negedge clock);
        check("t3_accepts", n_acc, 2);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        #1;
        check("t3_redir_req_vld", mem_req_valid, 0);
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        check("t3_addr", mem_addr, 16'h0100);
        check("t3_req_vld", mem_req_valid, 1);
        check("t3_c3_out_vld", out_valid, 0);
        repeat (3) @(negedge clock);
        check("t3_c6_out_vld", out_valid, 0);
        @(negedge clock);
        check("t3_c7_out_vld", out_valid, 1);
        check("t3_c7_out_pc", out_pc, 16'h0100);
        check("t3_no_stale", got_q.size(), 0);
`ifdef FETCH_PERF_EN
        check("t3_perf_flushed", perf_flushed, 2);
        check("t3_perf_fetched", perf_fetched, 0);
`endif
        repeat (6) @(negedge clock);
        check("t3_count", got_q.size() >= 2, 1);
        if (got_q.size() >= 2) begin
            check("t3_pc0", got_q[0], 16'h0100);
            check("t3_pc1", got_q[1], 16'h0101);
        end
`ifdef FETCH_PERF_EN
        check("t3_perf_fetched_run", perf_fetched, got_q.size());
`endif

        // Redirect coinciding with an out handshake and a memory response.
        lat = 1;
        out_ready = 1'b0;
        do_reset();
        repeat (3) @(negedge clock);
        check("t4_pre_out_vld", out_valid, 1);
        check("t4_pre_out_pc", out_pc, 16'h0000);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        @(negedge clock);
        redirect_valid = 1'b0;
        check("t4_flushed_out_vld", out_valid, 0);
        check("t4_delivered", got_q.size(), 1);
        if (got_q.size() >= 1) check("t4_delivered_pc", got_q[0], 16'h0000);
        #1;
        check("t4_addr", mem_addr, 16'h0200);
        check("t4_req_vld", mem_req_valid, 1);
`ifdef FETCH_PERF_EN
        check("t4_perf_flushed", perf_flushed, 2);
        check("t4_perf_fetched", perf_fetched, 1);
`endif
        repeat (2) @(negedge clock);
        check("t4_out_vld", out_valid, 1);
        check("t4_out_pc", out_pc, 16'h0200);

        // PC wrap at 0xFFFF.
        lat = 1;
        out_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        #1;
        check("t5_redir_req_vld", mem_req_valid, 0);
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        check("t5_addr_ffff", mem_addr, 16'hFFFF);
        check("t5_req_vld", mem_req_valid, 1);
        @(negedge clock);
        check("t5_addr_wrap", mem_addr, 16'h0000);
        repeat (6) @(negedge clock);
        check("t5_count", got_q.size() >= 3, 1);
        if (got_q.size() >= 3) begin
            check("t5_pc0", got_q[0], 16'hFFFF);
            check("t5_pc1", got_q[1], 16'h0000);
            check("t5_pc2", got_q[2], 16'h0001);
        end

`ifdef FETCH_PERF_EN
        // Counters track the run, then clear on a mid-run reset.
        check("t6_perf_fetched", perf_fetched, got_q.size());
        check("t6_perf_flushed", perf_flushed, 0);
        reset = 1'b1;
        @(negedge clock);
        check("t6_rst_fetched", perf_fetched, 0);
        check("t6_rst_flushed", perf_flushed, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
